mul_seq: RTL and testbench
==========================

# mul_seq

Sequential 32x32 multiplier that computes A*B with a shift-and-add datapath, one multiplier bit per clock. It is the arithmetic counterpart to the repeated-subtraction divider in the CPU execute stage. It takes the same operand, sign-control and result-select conventions, and adds an explicit start/ready handshake. The full 64-bit product is held internally; either half is presented on a 32-bit result bus.

## Interface
- `WIDTH`, 32: operand width. The product is 2*WIDTH.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `A` in 32: multiplicand. Sampled only on the edge that accepts `start`.
- `B` in 32: multiplier. Sampled only on the edge that accepts `start`.
- `signctl` in 1: 1 treats A and B as two's-complement signed; 0 treats them as unsigned. Sampled with the operands.
- `hi_out` in 1: 0 selects product[31:0] on `dout`; 1 selects product[63:32]. Live, not sampled.
- `start` in 1: request a new multiply. Accepted in IDLE or DONE only.
- `dout` out 32: selected product half. Combinational mux from the product register.
- `drdy` out 1: product valid. High only in DONE.
- `busy` out 1: high in CALC and FIX.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE → CALC** on `start`:
  - Latch `neg = signctl & (A[31]^B[31])`.
  - Latch `|A|` and `|B|`: two's-complement negation when `signctl` is set and the MSB is 1, else raw.
  - Clear the 64-bit accumulator. Clear the 5-bit bit counter.
- **CALC**, once per cycle:
  - If the multiplier LSB is 1, add the multiplicand magnitude into accumulator[63:32] with a 33-bit carry.
  - Shift the {carry, accumulator} right by 1, consuming one multiplier bit.
  - Increment the counter. When the counter reaches 31, go to FIX.
- **FIX**, one cycle:
  - If `neg`, the product becomes its 64-bit two's-complement negation; else unchanged.
  - Go to DONE.
- **DONE:**
  - `drdy`=1. The product is held indefinitely.
  - `start` in DONE behaves as in IDLE: new operands are latched, go to CALC, `drdy` falls.
- `start` in CALC or FIX is ignored. The operation in flight is unaffected.
- **Width rules:**
  - Unsigned results are exact over 64 bits.
  - Signed results are exact, including -2^31 * -2^31 = 2^62. The magnitude 0x80000000 is handled as unsigned 32-bit.
  - There is no overflow flag.
- **Reset**, at any time including mid-CALC or mid-FIX:
  - State goes to IDLE; accumulator, counter, `neg` and latched operands are cleared.
  - `drdy`=0, `busy`=0, `dout`=0.

## Timing
- The `start` edge is E0. Iterations occur on E1..E32. FIX occurs on E33.
- `drdy` is high after E33: 33 cycles from start acceptance to ready.
- Back-to-back: `start` asserted on the cycle `drdy` is first high is accepted. `drdy` drops after that edge.
- `dout` follows `hi_out` in the same cycle, with no register stage. `dout` is only meaningful while `drdy`=1.
- Operand and `signctl` changes after E0 have no effect on the result.
- All outputs reset to 0 asynchronously.

## Structure
- A shared package `mul_pkg` holds:
  - the state enum `mul_state_t` (IDLE, CALC, FIX, DONE);
  - `MUL_W`=32 and `MUL_CNT_W`=5;
  - a `twos_neg` function reused for operand and product negation.
- One sub-module, `mul_step`: a combinational single-iteration add-and-shift. Inputs are accumulator, multiplicand and multiplier LSB; output is the next accumulator. This keeps the FSM file free of datapath.

## Test plan
- Unsigned 0xFFFFFFFF * 0xFFFFFFFF, `signctl`=0 → `drdy` rises exactly 33 cycles after `start`; lo=0x00000001, hi=0xFFFFFFFE.
- Signed -3 * 7, `signctl`=1 → lo=0xFFFFFFEB, hi=0xFFFFFFFF. Same operands with `signctl`=0 → hi=0x00000006, lo=0xFFFFFFEB.
- Signed 0x80000000 * 0x80000000 → hi=0x40000000, lo=0x00000000. Also 0 * 0x12345678 → both halves 0.
- `start` pulsed at cycle 10 of CALC with different operands → ignored; the original product still appears at E33.
- Reset asserted mid-CALC at cycle 12 → `drdy`, `busy`, `dout` are 0 immediately. A fresh `start` of 6*7 → lo=42 at E33.
- In DONE, toggle `hi_out` each cycle → `dout` switches halves in the same cycle. `start` in DONE → `drdy` low next cycle, then the new result 33 cycles later.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int MUL_W     = 32;
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  // Two's-complement negation at product width; callers narrow the result
  // when negating a single operand.
  function automatic logic [2*MUL_W-1:0] twos_neg(input logic [2*MUL_W-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Operand / handshake / result bundle for mul_seq.
interface mul_seq_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signctl;
  logic             hi_out;
  logic             start;
  logic [WIDTH-1:0] dout;
  logic             drdy;
  logic             busy;

  modport master (
    output A, B, signctl, hi_out, start,
    input  dout, drdy, busy
  );

  modport slave (
    input  A, B, signctl, hi_out, start,
    output dout, drdy, busy
  );

endinterface

// File: rtl/mul_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// upper accumulator half, then shift {carry, accumulator} right by one.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               lsb,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] wide;

  // Add with carry-out, then drop the bit that falls off the bottom.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (lsb ? {1'b0, mcand} : '0);
    wide    = {sum, acc[WIDTH-1:0]};
    acc_nxt = wide[2*WIDTH:1];
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential WIDTHxWIDTH multiplier, one multiplier bit per clock.
// Signed operands are reduced to magnitudes up front and the product sign
// is restored in a single FIX cycle.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic       clk,
  input  logic       rst,
  mul_seq_if.slave   bus
);

  mul_state_t             state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   neg_q, neg_d;

  logic [2*WIDTH-1:0]     step_acc;
  logic [WIDTH-1:0]       mag_a, mag_b;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc_q),
    .mcand   (mcand_q),
    .lsb     (mplier_q[0]),
    .acc_nxt (step_acc)
  );

  // Operand magnitudes; 0x80000000 negates to itself and is then used unsigned.
  always_comb begin
    mag_a = (bus.signctl && bus.A[WIDTH-1]) ? WIDTH'(twos_neg({{WIDTH{1'b0}}, bus.A})) : bus.A;
    mag_b = (bus.signctl && bus.B[WIDTH-1]) ? WIDTH'(twos_neg({{WIDTH{1'b0}}, bus.B})) : bus.B;
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          neg_d    = bus.signctl & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          mcand_d  = mag_a;
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = step_acc;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Counter starts at 0, so the all-ones value marks the last of WIDTH iterations.
        if (cnt_q == '1) state_d = FIX;
      end
      FIX: begin
        if (neg_q) acc_d = twos_neg(acc_q);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags and live half-select of the product register.
  always_comb begin
    bus.drdy = (state_q == DONE);
    bus.busy = (state_q == CALC) || (state_q == FIX);
    bus.dout = bus.hi_out ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with hand-computed products.
module tb_mul_seq;

  logic clk;
  logic rst;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mul_seq_if #(.WIDTH(32)) bus ();

  mul_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge (E0), then scramble the
  // operand bus to show later changes are not sampled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.A       = a;
    bus.B       = b;
    bus.signctl = s;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.A       = ~a;
    bus.B       = ~b;
    bus.signctl = ~s;
  endtask

  // Count edges after E0 until drdy is seen; bounded.
  task automatic wait_rdy(input int offset, output int lat);
    bit found;
    found = 1'b0;
    lat   = offset;
    while (!found && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.drdy) found = 1'b1;
    end
  endtask

  task automatic read_prod(output logic [31:0] hi, output logic [31:0] lo);
    bus.hi_out = 1'b0;
    #1 lo = bus.dout;
    bus.hi_out = 1'b1;
    #1 hi = bus.dout;
    bus.hi_out = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    logic [31:0] hi, lo;
    start_op(a, b, s);
    wait_rdy(0, lat);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    read_prod(hi, lo);
    check({tag, "_hi"}, {32'h0, hi}, {32'h0, ehi});
    check({tag, "_lo"}, {32'h0, lo}, {32'h0, elo});
  endtask

  initial begin
    int lat;
    logic [31:0] hi, lo;

    rst         = 1'b1;
    bus.A       = '0;
    bus.B       = '0;
    bus.signctl = 1'b0;
    bus.hi_out  = 1'b0;
    bus.start   = 1'b0;
    #12;
    check("rst_drdy", {63'h0, bus.drdy}, 64'd0);
    check("rst_busy", {63'h0, bus.busy}, 64'd0);
    check("rst_dout", {32'h0, bus.dout}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_and_check("u_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_and_check("s_m3x7",  32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_and_check("u_m3x7",  32'hFFFFFFFD, 32'h00000007, 1'b0, 32'h00000006, 32'hFFFFFFEB);
    run_and_check("s_min2",  32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
    run_and_check("zero",    32'h00000000, 32'h12345678, 1'b0, 32'h00000000, 32'h00000000);

    // start during CALC is ignored
    start_op(32'h00001234, 32'h00000010, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("calc_busy", {63'h0, bus.busy}, 64'd1);
    check("calc_drdy", {63'h0, bus.drdy}, 64'd0);
    @(negedge clk);
    bus.A     = 32'hFFFFFFFF;
    bus.B     = 32'h00000003;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_rdy(10, lat);
    check("ign_lat", 64'(lat), 64'd33);
    read_prod(hi, lo);
    check("ign_hi", {32'h0, hi}, 64'h0);
    check("ign_lo", {32'h0, lo}, 64'h0001_2340);

    // asynchronous reset mid-CALC
    start_op(32'hDEADBEEF, 32'h11111111, 1'b1);
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_drdy", {63'h0, bus.drdy}, 64'd0);
    check("mrst_busy", {63'h0, bus.busy}, 64'd0);
    check("mrst_dlo", {32'h0, bus.dout}, 64'd0);
    bus.hi_out = 1'b1;
    #1;
    check("mrst_dhi", {32'h0, bus.dout}, 64'd0);
    bus.hi_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_and_check("after_rst", 32'd6, 32'd7, 1'b0, 32'h0, 32'd42);

    // live hi_out in DONE, then back-to-back start
    run_and_check("halves", 32'h12345678, 32'h00000100, 1'b0, 32'h00000012, 32'h34567800);
    for (int i = 0; i < 6; i++) begin
      bus.hi_out = i[0];
      #1;
      check("tog_dout", {32'h0, bus.dout}, i[0] ? 64'h12 : 64'h3456_7800);
    end
    bus.hi_out = 1'b0;
    @(posedge clk);
    #1;
    check("hold_drdy", {63'h0, bus.drdy}, 64'd1);
    check("hold_lo", {32'h0, bus.dout}, 64'h3456_7800);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("b2b_drdy", {63'h0, bus.drdy}, 64'd0);
    check("b2b_busy", {63'h0, bus.busy}, 64'd1);
    wait_rdy(0, lat);
    check("b2b_lat", 64'(lat), 64'd33);
    read_prod(hi, lo);
    check("b2b_hi", {32'h0, hi}, 64'h0);
    check("b2b_lo", {32'h0, lo}, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
